// File: rtl/mac_array.sv
// mac_array: matrix-multiply engine computing O = I x W.
//
// Operand rows of I and of W-transposed are read from two synchronous SRAMs
// (one-cycle read latency) into eight-row operand register banks. The 8x8
// result (16-bit elements) is then written as sixteen 64-bit words to an
// output SRAM. Each word holds four dot products. Rows t >= T and columns
// m >= M are written as zero. Elements with index n >= N contribute nothing.
//
// Configuration macro: MAC_ARRAY_SIGNED_EN
//   defined     -> 4-bit elements are two's complement; results sign-extended.
//   not defined -> 4-bit elements are unsigned; results zero-extended.
//
// Ports:
//   CLK      in   1   clock, rising edge
//   RSTN     in   1   asynchronous reset, active HIGH (legacy name)
//   MNT      in  12   {M, N, T} nibbles, latched when a run starts
//   START    in   1   run request, sampled only while idle
//   EN_I     out  1   input SRAM enable
//   EN_W     out  1   weight SRAM enable
//   ADDR_I   out  4   input SRAM row address
//   ADDR_W   out  4   weight SRAM row address (always equal to ADDR_I)
//   RDATA_I  in  32   input row, element 1 in [31:28]
//   RDATA_W  in  32   weight-transposed row, element 1 in [31:28]
//   EN_O     out  1   output SRAM enable
//   RW_O     out  1   output SRAM write strobe (1 = write)
//   ADDR_O   out  4   output word address
//   WDATA_O  out 64   four 16-bit results, lowest column in [63:48]
//   RDATA_O  in  64   output SRAM read data, not used
module mac_array (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [11:0] MNT,
  input  logic        START,
  output logic        EN_I,
  output logic        EN_W,
  output logic [3:0]  ADDR_I,
  output logic [3:0]  ADDR_W,
  input  logic [31:0] RDATA_I,
  input  logic [31:0] RDATA_W,
  output logic        EN_O,
  output logic        RW_O,
  output logic [3:0]  ADDR_O,
  output logic [63:0] WDATA_O,
  input  logic [63:0] RDATA_O
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [3:0]  t_r, n_r, m_r;
  logic [31:0] in_reg_r [8];
  logic [31:0] wt_reg_r [8];

  logic        en_rd_r, en_rd_s;
  logic [3:0]  addr_rd_r, addr_rd_s;
  logic        en_wr_r, en_wr_s;
  logic [3:0]  addr_o_r, addr_o_s;
  logic [63:0] wdata_r, wdata_s;

  logic        cap_en_s;
  logic [2:0]  cap_idx_s;
  logic [2:0]  row_s;
  logic [2:0]  col_s;
  logic        unused_rdata_s;

  // Dimension nibbles above 8 mean "the full 8".
  function automatic logic [3:0] clamp8(input logic [3:0] v);
    logic [3:0] r;
    if (v > 4'd8) begin
      r = 4'd8;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Widen one 4-bit element to the 16-bit accumulation width.
  function automatic logic [15:0] ext16(input logic [3:0] e);
`ifdef MAC_ARRAY_SIGNED_EN
    return {{12{e[3]}}, e};
`else
    return {12'd0, e};
`endif
  endfunction

  // 8-term dot product; terms at index >= n are masked off. Modulo-2^16
  // arithmetic gives the right answer in both signed and unsigned builds.
  function automatic logic [15:0] dot8(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [3:0]  n);
    logic [15:0] acc;
    logic [15:0] pa;
    logic [15:0] pb;
    acc = 16'd0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < n) begin
        pa  = ext16(a[(31 - 4*i) -: 4]);
        pb  = ext16(b[(31 - 4*i) -: 4]);
        acc = acc + pa * pb;
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  assign unused_rdata_s = ^RDATA_O;

  // Next-state and sequence counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_s = ST_LOAD;
          cnt_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end
      end
      ST_LOAD: begin
        if (cnt_r == 4'd7) begin
          state_s = ST_CAPT;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r + 4'd1;
        end
      end
      ST_CAPT: begin
        state_s = ST_WRITE;
        cnt_s   = 4'd0;
      end
      ST_WRITE: begin
        if (cnt_r == 4'd15) begin
          state_s = ST_DONE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Read data lags the address by one cycle, so row r is captured while
  // address r+1 is being issued; row 7 lands during CAPT.
  always_comb begin
    cap_en_s  = 1'b0;
    cap_idx_s = 3'd0;
    if ((state_r == ST_LOAD) && (cnt_r != 4'd0)) begin
      cap_en_s  = 1'b1;
      cap_idx_s = 3'(cnt_r - 4'd1);
    end else if (state_r == ST_CAPT) begin
      cap_en_s  = 1'b1;
      cap_idx_s = 3'd7;
    end else begin
      cap_en_s  = 1'b0;
      cap_idx_s = 3'd0;
    end
  end

  // Output values for the coming cycle, computed from the next state so all
  // memory-side outputs can be registered without adding latency.
  always_comb begin
    en_rd_s   = 1'b0;
    addr_rd_s = 4'd0;
    en_wr_s   = 1'b0;
    addr_o_s  = 4'd0;
    wdata_s   = 64'd0;
    row_s     = cnt_s[2:0];
    col_s     = 3'd0;
    if (state_s == ST_LOAD) begin
      en_rd_s   = 1'b1;
      addr_rd_s = cnt_s;
    end else begin
      en_rd_s   = 1'b0;
      addr_rd_s = 4'd0;
    end
    if (state_s == ST_WRITE) begin
      en_wr_s  = 1'b1;
      addr_o_s = cnt_s;
      // Word c covers row c[2:0] and columns 4*c[3] .. 4*c[3]+3.
      for (int j = 0; j < 4; j++) begin
        col_s = {cnt_s[3], 2'(j)};
        if (({1'b0, row_s} < t_r) && ({1'b0, col_s} < m_r)) begin
          wdata_s[(63 - 16*j) -: 16] = dot8(in_reg_r[row_s], wt_reg_r[col_s], n_r);
        end else begin
          wdata_s[(63 - 16*j) -: 16] = 16'd0;
        end
      end
    end else begin
      en_wr_s  = 1'b0;
      addr_o_s = 4'd0;
      wdata_s  = 64'd0;
    end
  end

  // State, counter, latched dimensions and registered memory outputs.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      t_r       <= 4'd0;
      n_r       <= 4'd0;
      m_r       <= 4'd0;
      en_rd_r   <= 1'b0;
      addr_rd_r <= 4'd0;
      en_wr_r   <= 1'b0;
      addr_o_r  <= 4'd0;
      wdata_r   <= 64'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      en_rd_r   <= en_rd_s;
      addr_rd_r <= addr_rd_s;
      en_wr_r   <= en_wr_s;
      addr_o_r  <= addr_o_s;
      wdata_r   <= wdata_s;
      if ((state_r == ST_IDLE) && START) begin
        t_r <= clamp8(MNT[3:0]);
        n_r <= clamp8(MNT[7:4]);
        m_r <= clamp8(MNT[11:8]);
      end
    end
  end

  // Operand register banks.
  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      for (int r = 0; r < 8; r++) begin
        in_reg_r[r] <= 32'd0;
        wt_reg_r[r] <= 32'd0;
      end
    end else if (cap_en_s) begin
      in_reg_r[cap_idx_s] <= RDATA_I;
      wt_reg_r[cap_idx_s] <= RDATA_W;
    end
  end

  assign EN_I    = en_rd_r;
  assign EN_W    = en_rd_r;
  assign ADDR_I  = addr_rd_r;
  assign ADDR_W  = addr_rd_r;
  assign EN_O    = en_wr_r;
  assign RW_O    = en_wr_r;
  assign ADDR_O  = addr_o_r;
  assign WDATA_O = wdata_r;

endmodule

// File: tb/tb_mac_array.sv
`timescale 1ns/1ps
module tb_mac_array;

  logic        CLK;
  logic        RSTN;
  logic [11:0] MNT;
  logic        START;
  logic        EN_I, EN_W, EN_O, RW_O;
  logic [3:0]  ADDR_I, ADDR_W, ADDR_O;
  logic [31:0] RDATA_I, RDATA_W;
  logic [63:0] WDATA_O, RDATA_O;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] imem [8];
  logic [31:0] wmem [8];
  logic [63:0] omem [16];
  logic        clr_omem;

  // Behavioural run model: ph = -1 idle, 0..25 position within a run.
  int          ph = -1;
  logic [11:0] run_mnt = 12'd0;

  logic        exp_rd, exp_wr;
  logic [63:0] exp_w;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign RDATA_O = 64'd0;

  mac_array dut (
    .CLK(CLK), .RSTN(RSTN), .MNT(MNT), .START(START),
    .EN_I(EN_I), .EN_W(EN_W), .ADDR_I(ADDR_I), .ADDR_W(ADDR_W),
    .RDATA_I(RDATA_I), .RDATA_W(RDATA_W),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O),
    .WDATA_O(WDATA_O), .RDATA_O(RDATA_O)
  );

  // Input and weight SRAMs, one-cycle read latency.
  always @(posedge CLK) begin
    if (EN_I) RDATA_I <= imem[ADDR_I[2:0]];
    if (EN_W) RDATA_W <= wmem[ADDR_W[2:0]];
  end

  // Output SRAM; cleared to a sentinel before each run.
  always @(posedge CLK) begin
    if (clr_omem) begin
      for (int i = 0; i < 16; i++) omem[i] <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (EN_O && RW_O) begin
      omem[ADDR_O] <= WDATA_O;
    end
  end

  // Run timing model: START sampled while idle, 26 busy cycles.
  always @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      ph <= -1;
    end else if (ph < 0) begin
      if (START) begin
        ph      <= 0;
        run_mnt <= MNT;
      end
    end else if (ph == 25) begin
      ph <= -1;
    end else begin
      ph <= ph + 1;
    end
  end

  function automatic int lim(input logic [3:0] v);
    return (v > 4'd8) ? 8 : int'(v);
  endfunction

  function automatic int elem(input logic [31:0] row, input int k);
    int v;
    v = int'((row >> (28 - 4*k)) & 32'hF);
`ifdef MAC_ARRAY_SIGNED_EN
    if (v > 7) v = v - 16;
`endif
    return v;
  endfunction

  // Expected output word c from the matrices and the latched dimensions.
  function automatic logic [63:0] exp_word(input int c, input logic [11:0] mnt);
    int tt, nn, mm, t, m, s;
    logic [63:0] w;
    logic [15:0] r16;
    tt = lim(mnt[3:0]);
    nn = lim(mnt[7:4]);
    mm = lim(mnt[11:8]);
    t  = c % 8;
    w  = 64'd0;
    for (int j = 0; j < 4; j++) begin
      m = 4 * (c / 8) + j;
      s = 0;
      if (t < tt && m < mm) begin
        for (int k = 0; k < nn; k++) s += elem(imem[t], k) * elem(wmem[m], k);
      end
      r16 = 16'(s);
      w   = (w << 16) | {48'd0, r16};
    end
    return w;
  endfunction

  // Per-cycle comparison of every memory-side output against the model.
  always @(negedge CLK) begin
    if (RSTN === 1'b0) begin
      exp_rd = (ph >= 0 && ph <= 7);
      exp_wr = (ph >= 9 && ph <= 24);
      n_tests++;
      if (EN_I !== exp_rd || EN_W !== exp_rd || EN_O !== exp_wr) begin
        n_fail++;
        $display("FAIL enables ph=%0d got EN_I=%b EN_W=%b EN_O=%b need rd=%b wr=%b",
                 ph, EN_I, EN_W, EN_O, exp_rd, exp_wr);
      end
      if (exp_rd) begin
        n_tests++;
        if (ADDR_I !== 4'(ph) || ADDR_W !== 4'(ph)) begin
          n_fail++;
          $display("FAIL rd_addr ph=%0d got ADDR_I=%0d ADDR_W=%0d need %0d", ph, ADDR_I, ADDR_W, ph);
        end
      end
      if (exp_wr) begin
        exp_w = exp_word(ph - 9, run_mnt);
        n_tests++;
        if (RW_O !== 1'b1 || ADDR_O !== 4'(ph - 9) || WDATA_O !== exp_w) begin
          n_fail++;
          $display("FAIL write ph=%0d got RW_O=%b ADDR_O=%0d WDATA_O=%h need RW_O=1 ADDR_O=%0d WDATA_O=%h",
                   ph, RW_O, ADDR_O, WDATA_O, ph - 9, exp_w);
        end
      end
    end
  end

  task automatic fill(input logic [31:0] iv, input logic [31:0] wv);
    for (int r = 0; r < 8; r++) begin
      imem[r] = iv;
      wmem[r] = wv;
    end
  endtask

  task automatic wait_ph(input int p);
    for (int k = 0; k < 80 && ph != p; k++) @(negedge CLK);
    if (ph != p) begin
      n_fail++;
      $display("FAIL wait_phase timeout got ph=%0d need %0d", ph, p);
    end
  endtask

  // Start one run with a one-cycle START pulse and wait for its DONE cycle.
  task automatic do_run(input logic [11:0] mnt);
    @(negedge CLK);
    clr_omem = 1'b1;
    MNT      = mnt;
    START    = 1'b1;
    @(negedge CLK);
    clr_omem = 1'b0;
    START    = 1'b0;
    wait_ph(25);
  endtask

  task automatic chk_word(input int a, input logic [63:0] e);
    n_tests++;
    if (omem[a] !== e) begin
      n_fail++;
      $display("FAIL omem[%0d] got %h need %h", a, omem[a], e);
    end
  endtask

  task automatic chk_zero(input string nm);
    n_tests++;
    if (EN_I !== 1'b0 || EN_W !== 1'b0 || EN_O !== 1'b0 || RW_O !== 1'b0 ||
        ADDR_I !== 4'd0 || ADDR_W !== 4'd0 || ADDR_O !== 4'd0 || WDATA_O !== 64'd0) begin
      n_fail++;
      $display("FAIL %s got EN_I=%b EN_W=%b EN_O=%b RW_O=%b ADDR_I=%0d ADDR_O=%0d WDATA_O=%h need all 0",
               nm, EN_I, EN_W, EN_O, RW_O, ADDR_I, ADDR_O, WDATA_O);
    end
  endtask

  task automatic chk_444;
    for (int a = 0; a < 16; a++) chk_word(a, (a < 4) ? 64'h0004_0004_0004_0004 : 64'd0);
  endtask

  initial begin
    RSTN     = 1'b0;
    MNT      = 12'd0;
    START    = 1'b0;
    clr_omem = 1'b0;
    RDATA_I  = 32'd0;
    RDATA_W  = 32'd0;
    fill(32'd0, 32'd0);
    #1 RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    chk_zero("reset_values");
    RSTN = 1'b0;

    fill(32'h1111_1111, 32'h1111_1111);
    do_run(12'h444);
    chk_444();

    do_run(12'h888);
    for (int a = 0; a < 16; a++) chk_word(a, 64'h0008_0008_0008_0008);

    do_run(12'h644);
    for (int a = 0; a < 16; a++)
      chk_word(a, (a < 4) ? 64'h0004_0004_0004_0004 :
                  (a >= 8 && a < 12) ? 64'h0004_0004_0000_0000 : 64'd0);

    do_run(12'h446);
    for (int a = 0; a < 16; a++) chk_word(a, (a < 6) ? 64'h0004_0004_0004_0004 : 64'd0);

    do_run(12'h000);
    for (int a = 0; a < 16; a++) chk_word(a, 64'd0);

    fill(32'hFFFF_FFFF, 32'h1111_1111);
    do_run(12'h888);
`ifdef MAC_ARRAY_SIGNED_EN
    for (int a = 0; a < 16; a++) chk_word(a, 64'hFFF8_FFF8_FFF8_FFF8);
`else
    for (int a = 0; a < 16; a++) chk_word(a, 64'h0078_0078_0078_0078);
`endif

    // START held high; MNT changes mid-run and is picked up by the next run.
    fill(32'h1111_1111, 32'h1111_1111);
    @(negedge CLK);
    clr_omem = 1'b1;
    MNT      = 12'h444;
    START    = 1'b1;
    @(negedge CLK);
    clr_omem = 1'b0;
    wait_ph(12);
    MNT = 12'h666;
    wait_ph(25);
    chk_444();
    @(negedge CLK);
    clr_omem = 1'b1;
    @(negedge CLK);
    clr_omem = 1'b0;
    START    = 1'b0;
    wait_ph(25);
    for (int a = 0; a < 16; a++)
      chk_word(a, (a < 6) ? 64'h0006_0006_0006_0006 :
                  (a >= 8 && a < 14) ? 64'h0006_0006_0000_0000 : 64'd0);

    // Asynchronous reset during WRITE, then a clean run.
    @(negedge CLK);
    MNT   = 12'h888;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_ph(15);
    #2 RSTN = 1'b1;
    #1 chk_zero("async_reset_mid_write");
    @(negedge CLK);
    RSTN = 1'b0;
    do_run(12'h444);
    chk_444();

    // Randomized matrices and dimensions, checked cycle by cycle.
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < 8; k++) begin
        imem[k] = $urandom;
        wmem[k] = $urandom;
      end
      if (r == 0)      do_run(12'hFFF);
      else if (r == 1) do_run(12'h808);
      else             do_run(12'($urandom_range(0, 4095)));
      for (int a = 0; a < 16; a++) chk_word(a, exp_word(a, run_mnt));
    end

    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
